// File: rtl/lc3b_types.sv
// Shared LC-3b data-memory types: bus words, byte masks, responder state and request payload.
package lc3b_types;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned MASK_W = 2;
    localparam int unsigned CNT_W  = 4;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [MASK_W-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic          write;
        lc3b_mem_wmask byte_enable;
        lc3b_word      address;
        lc3b_word      wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with synchronous two-lane byte write and combinational read.
module dmem_array
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  lc3b_mem_wmask                  be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  lc3b_word                       wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output lc3b_word                       rdata_c
);

    lc3b_word mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[waddr][7:0]  <= wdata[7:0];
            if (be[1]) mem[waddr][15:8] <= wdata[15:8];
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, waits LATENCY cycles, acks once.
module dmem_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dmem_action_cyc,
    input  logic          dmem_action_stb,
    input  logic          dmem_write,
    input  lc3b_mem_wmask dmem_byte_enable,
    input  lc3b_word      dmem_address,
    input  lc3b_word      dmem_wdata,
    output logic          dmem_resp,
    output lc3b_word      dmem_rdata
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_e      state;
    logic [CNT_W-1:0] cnt;
    dmem_req_t        req_q;

    logic [AW-1:0] waddr_c;
    logic [AW-1:0] raddr_c;
    logic          we_c;
    lc3b_word      rd_word_c;

    // Byte address bit 0 and bits above the array size are dropped, so addresses wrap.
    assign waddr_c = req_q.address[AW:1];
    assign raddr_c = (state == IDLE) ? dmem_address[AW:1] : req_q.address[AW:1];
    assign we_c    = (state == ACK) && req_q.write && !rst;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we      (we_c),
        .be      (req_q.byte_enable),
        .waddr   (waddr_c),
        .wdata   (req_q.wdata),
        .raddr   (raddr_c),
        .rdata_c (rd_word_c)
    );

    // Read data is loaded on the edge that enters ACK and cleared on every other edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            dmem_resp  <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            dmem_resp  <= 1'b0;
            dmem_rdata <= '0;
            case (state)
                IDLE: begin
                    if (dmem_action_cyc && dmem_action_stb) begin
                        req_q.write       <= dmem_write;
                        req_q.byte_enable <= dmem_byte_enable;
                        req_q.address     <= dmem_address;
                        req_q.wdata       <= dmem_wdata;
                        if (LATENCY == 1) begin
                            state      <= ACK;
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= dmem_write ? '0 : rd_word_c;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (!dmem_action_cyc) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        state      <= ACK;
                        cnt        <= '0;
                        dmem_resp  <= 1'b1;
                        dmem_rdata <= req_q.write ? '0 : rd_word_c;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request acceptance to dmem_resp (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 16-bit words stored (power of two, 2..32768).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dmem_action_cyc  input  1  bus cycle active.
REQ-006 SHALL have port dmem_action_stb  input  1  request strobe.
REQ-007 SHALL have port dmem_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port dmem_byte_enable  input  lc3b_mem_wmask (2)  bit1 = high byte, bit0 = low byte.
REQ-009 SHALL have port dmem_address  input  lc3b_word (16)  byte address.
REQ-010 SHALL have port dmem_wdata  input  lc3b_word (16)  write data.
REQ-011 SHALL have port dmem_resp  output  1  one-cycle acknowledge.
REQ-012 SHALL have port dmem_rdata  output  lc3b_word (16)  read data, valid while dmem_resp = 1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-014 IDLE: when cyc & stb = 1 at a clock edge, SHALL capture address, write, byte_enable and wdata into registers, then enter BUSY with wait counter = LATENCY-1; if LATENCY = 1, SHALL enter ACK directly.
REQ-015 BUSY: SHALL decrement the counter each cycle and enter ACK when the counter reaches 0, so a request sampled at edge N gives dmem_resp = 1 in cycle N+LATENCY.
REQ-016 ACK: dmem_resp SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-017 Back-to-back: a strobe held high through ACK SHALL be sampled again in the following IDLE cycle, so throughput is one access per LATENCY+1 cycles.
REQ-018 Word index SHALL be captured address bits [log2(DEPTH_WORDS):1]; bit 0 and higher bits SHALL be ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
REQ-019 Write SHALL commit to the array at the ACK-cycle edge, updating only the byte lanes whose enable bit = 1; byte_enable = 00 SHALL leave the array unchanged but still acknowledge.
REQ-020 Read SHALL drive the full 16-bit stored word on dmem_rdata during ACK regardless of byte_enable; dmem_rdata SHALL hold 0 in all other cycles.
REQ-021 Abort: if cyc = 0 in any BUSY cycle, the FSM SHALL return to IDLE at the next edge with no write and no dmem_resp.
REQ-022 Inputs SHALL be ignored outside IDLE except for cyc (abort); stb deassertion while BUSY SHALL NOT abort.
REQ-023 A read from a word in the cycle after a write to it acks SHALL return the new data.

Reset
REQ-024 When rst = 1 at an edge: state SHALL be IDLE, dmem_resp = 0, dmem_rdata = 0, counter = 0, and captured registers = 0.
REQ-025 rst asserted during BUSY or ACK SHALL cancel the request with no array write and no dmem_resp.
REQ-026 Array contents SHALL NOT be cleared by reset; simulation SHALL initialise all words to 0.

Structure
REQ-027 State enum (IDLE/BUSY/ACK) SHALL be declared in lc3b_types; lc3b_word and lc3b_mem_wmask SHALL come from lc3b_types.
REQ-028 The storage array SHALL be a separate sub-module dmem_array (synchronous two-lane byte write, combinational read), and the FSM and counter SHALL remain in dmem_responder.

Verification
REQ-029 Reset, then write 0xBEEF to 0x0010 with be = 11 at LATENCY 2 -> resp high exactly at cycle 2 after acceptance; a read of 0x0010 then returns 0xBEEF.
REQ-030 Write 0x1234 to 0x0020 with be = 11, then write 0xAB55 to 0x0021 with be = 10 -> a read of 0x0020 returns 0xAB34; be = 00 write leaves 0xAB34.
REQ-031 With cyc and stb held high across two accesses (LDI-style) -> exactly two one-cycle resp pulses 3 cycles apart.
REQ-032 Accept a write, then drop cyc in the first BUSY cycle -> no resp, and the word is unchanged.
REQ-033 Assert rst during BUSY of a write -> no resp, word unchanged, FSM idle; with DEPTH_WORDS 256, address 0x0202 aliases 0x0002.
REQ-034 With LATENCY = 1 -> resp occurs in the cycle immediately after acceptance, and dmem_rdata = 0 whenever resp = 0.
